i2c_sda_byte_engine: RTL and testbench
======================================

Name: i2c_sda_byte_engine

Overview:
Parametrised successor to the combinational SDA tristate driver. It is a sequenced I2C master bit/byte engine that generates SCL and drives open-drain SDA itself. It executes one command per Go strobe: START, WRITE byte, READ byte or STOP. It sits between a transaction-level I2C controller FSM and the bus pins.

Parameters:
DATA_WIDTH, 8, bits per data phase (shifted MSB first), ack bit excluded
CLK_DIV, 4, Clock cycles per SCL quarter-period (>=1); one bit time = 4*CLK_DIV cycles

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high
Go  input  1  command strobe, accepted only when Busy=0
Cmd  input  2  00=START, 01=WRITE, 10=READ, 11=STOP; sampled with Go
TxData  input  DATA_WIDTH  write byte; sampled with Go
SendAck  input  1  READ only: 1 = drive ACK (SDA low) on 9th bit, 0 = NACK; sampled with Go
RxData  output  DATA_WIDTH  byte received by last READ
AckReceived  output  1  WRITE only: 1 = slave pulled SDA low on 9th bit
ArbLost  output  1  sticky: SDA read 0 while engine released it during a WRITE data bit
Busy  output  1  command in progress
Done  output  1  one-cycle completion pulse
SCL  output  1  push-pull bus clock (no clock stretching)
SDA  inout  1  open drain: driven 0 or high-Z, never driven 1

Behaviour:
- Reset, including mid-command: SDA released (Z), SCL=1, Busy=0, Done=0, RxData=0, AckReceived=0, ArbLost=0. The state machine returns to IDLE. No STOP is generated.
- States: IDLE, START, BIT (data/ack), STOP. A quarter counter runs 0..CLK_DIV-1 and a phase counter runs Q0..Q3. The bit index runs DATA_WIDTH..0, where 0 is the ack bit.
- Accept: on an edge with Go=1 and Busy=0, latch Cmd, TxData and SendAck, clear ArbLost, and set Busy=1. Go while Busy=1 is ignored.
- Duration: START and STOP take 4*CLK_DIV cycles. WRITE and READ take (DATA_WIDTH+1)*4*CLK_DIV cycles. Busy stays high for exactly that many cycles.
- Completion: on the edge ending the final quarter, Busy falls to 0 and Done is 1 for exactly one cycle. A Go in the Done cycle is accepted (back-to-back commands).
- START phases (SDA/SCL): Q0 Z/1, Q1 Z/1, Q2 0/1, Q3 0/0.
- STOP phases (SDA/SCL): Q0 0/0, Q1 0/1, Q2 Z/1, Q3 Z/1.
- Data/ack bit: SDA is set up in Q0 with SCL=0. SCL=1 during Q1 and Q2, then SCL=0 in Q3. SDA is sampled on the first cycle of Q2. SDA changes only while SCL=0.
- Between commands: SCL and SDA hold their last Q3 value. After START or a data command this is SCL=0. After STOP this is SCL=1 with SDA released.
- WRITE data bits: a bit value of 0 drives SDA low; a bit value of 1 releases SDA.
  - If SDA is sampled 0 on a released bit, ArbLost is set to 1.
  - After ArbLost is set, SDA stays released for the rest of the byte. Clocking continues and Done still pulses.
- WRITE ack bit: SDA is released. AckReceived = inverse of sampled SDA, updated at the ack sample point.
- READ data bits: SDA is released and the sampled value is shifted into a shift register MSB first. RxData updates only at Done.
- READ ack bit: SDA is driven low if SendAck=1, otherwise released.
- AckReceived and RxData hold their values until the next command of their own type completes.
- The SDA input is used directly; the bus is assumed synchronised externally.

Test Plan:
- Reset held 3 cycles, then released -> SDA=Z, SCL=1, Busy=0, Done=0, RxData=0. Go with Cmd=00 -> SDA falls while SCL=1 exactly 2*CLK_DIV cycles after Busy rises; Done pulses 16 cycles after acceptance (CLK_DIV=4).
- WRITE TxData=8'hA5 with the bench pulling SDA low on the 9th bit -> the SDA pattern at the 8 SCL rising edges is 1,0,1,0,0,1,0,1. AckReceived=1, ArbLost=0, Busy high for 144 cycles.
- WRITE 8'hFF with the bench pulling SDA low during bit 5 -> ArbLost=1 from that sample point onward. SDA stays released afterwards and Done still pulses at 144 cycles.
- READ with SendAck=0 and the bench driving 8'h3C -> RxData=8'h3C at Done, and SDA is released (NACK) during the 9th bit.
- Go asserted every cycle -> commands are accepted only on the Done cycle. Then STOP -> SDA rises while SCL=1 and the final state is SCL=1, SDA=Z.
- Reset asserted mid-READ at bit 3 -> on the next edge SCL=1, SDA=Z, Busy=0, no Done pulse, and RxData=0.

Source files
------------

// File: rtl/i2c_sda_byte_engine.sv
// I2C master bit/byte engine: START, WRITE, READ or STOP per Go strobe, with its own SCL and open-drain SDA.
// START/STOP take 4*CLK_DIV cycles, WRITE/READ (DATA_WIDTH+1)*4*CLK_DIV; Go is ignored while Busy, and a Go in the Done cycle is accepted.
module i2c_sda_byte_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Go,
    input  logic [1:0]            Cmd,
    input  logic [DATA_WIDTH-1:0] TxData,
    input  logic                  SendAck,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  AckReceived,
    output logic                  ArbLost,
    output logic                  Busy,
    output logic                  Done,
    output logic                  SCL,
    inout  wire                   SDA
);
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, START, BIT, STOP} stateT;

    stateT                 state, stateNext;
    logic [QW-1:0]         quarter;
    logic [1:0]            phase;
    logic [BW-1:0]         bitIdx;
    logic                  isRead;
    logic                  sendAckReg;
    logic [DATA_WIDTH-1:0] txShift;
    logic [DATA_WIDTH-1:0] rxShift;
    logic                  sclHold, sdaLowHold;
    logic                  sclOut, sdaLowOut;
    logic                  quarterEnd, lastQuarter, samplePoint, sdaIn;

    assign sdaIn       = SDA;
    assign SDA         = sdaLowOut ? 1'b0 : 1'bz;
    assign SCL         = sclOut;
    assign Busy        = (state != IDLE);
    assign quarterEnd  = (quarter == QW'(CLK_DIV - 1));
    assign lastQuarter = Busy && quarterEnd && (phase == 2'd3) && (state != BIT || bitIdx == '0);
    assign samplePoint = (state == BIT) && (phase == 2'd2) && (quarter == '0);

    always_comb begin
        stateNext = state;
        sclOut    = sclHold;
        sdaLowOut = sdaLowHold;
        case (state)
            IDLE: begin
                if (Go) begin
                    case (Cmd)
                        2'b00:   stateNext = START;
                        2'b11:   stateNext = STOP;
                        default: stateNext = BIT;
                    endcase
                end
            end
            START: begin
                sclOut    = (phase != 2'd3);
                sdaLowOut = phase[1];
            end
            STOP: begin
                sclOut    = (phase != 2'd0);
                sdaLowOut = ~phase[1];
            end
            default: begin
                sclOut = (phase == 2'd1) || (phase == 2'd2);
                // Ack slot belongs to the master only on READ; once arbitration is lost the byte runs out released.
                if (bitIdx == '0)
                    sdaLowOut = isRead && sendAckReg;
                else
                    sdaLowOut = !isRead && !ArbLost && !txShift[DATA_WIDTH-1];
            end
        endcase
        if (state != IDLE && lastQuarter)
            stateNext = IDLE;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            quarter     <= '0;
            phase       <= 2'd0;
            bitIdx      <= '0;
            isRead      <= 1'b0;
            sendAckReg  <= 1'b0;
            txShift     <= '0;
            rxShift     <= '0;
            sclHold     <= 1'b1;
            sdaLowHold  <= 1'b0;
            RxData      <= '0;
            AckReceived <= 1'b0;
            ArbLost     <= 1'b0;
            Done        <= 1'b0;
        end else begin
            state <= stateNext;
            Done  <= lastQuarter;
            if (state == IDLE) begin
                if (Go) begin
                    quarter    <= '0;
                    phase      <= 2'd0;
                    bitIdx     <= BW'(DATA_WIDTH);
                    isRead     <= (Cmd == 2'b10);
                    sendAckReg <= SendAck;
                    txShift    <= TxData;
                    ArbLost    <= 1'b0;
                end
            end else begin
                // Pins keep their last driven level between commands.
                sclHold    <= sclOut;
                sdaLowHold <= sdaLowOut;
                if (quarterEnd) begin
                    quarter <= '0;
                    phase   <= phase + 2'd1;
                    if (phase == 2'd3 && state == BIT) begin
                        bitIdx  <= bitIdx - BW'(1);
                        txShift <= txShift << 1;
                    end
                end else begin
                    quarter <= quarter + QW'(1);
                end
                if (samplePoint) begin
                    if (bitIdx != '0) begin
                        if (isRead)
                            rxShift <= (rxShift << 1) | DATA_WIDTH'(sdaIn);
                        else if (!sdaLowOut && !sdaIn)
                            ArbLost <= 1'b1;
                    end else if (!isRead) begin
                        AckReceived <= ~sdaIn;
                    end
                end
                if (lastQuarter && state == BIT && isRead)
                    RxData <= rxShift;
            end
        end
    end
endmodule

// File: tb/tb_i2c_sda_byte_engine.sv
// Directed and randomized bench for i2c_sda_byte_engine with an open-drain bus and a bit-level bus model.
module tb_i2c_sda_byte_engine;
    localparam int DW = 8;
    localparam int CD = 4;
    localparam int BT = 4 * CD;
    localparam int NMAX = (DW + 1) * BT;

    logic          Clock = 1'b0;
    logic          Reset, Go, SendAck;
    logic [1:0]    Cmd;
    logic [DW-1:0] TxData, RxData;
    logic          AckReceived, ArbLost, Busy, Done, SCL;
    wire           sdaBus;
    logic          slaveLow;

    int total = 0;
    int bad   = 0;

    logic sclLog  [0:NMAX];
    logic sdaLog  [0:NMAX];
    logic busyLog [0:NMAX];
    logic doneLog [0:NMAX];
    logic arbLog  [0:NMAX];

    logic [DW-1:0] lastRx;
    logic          lastAck;

    assign sdaBus = slaveLow ? 1'b0 : 1'bz;
    pullup (sdaBus);

    always #5 Clock = ~Clock;

    i2c_sda_byte_engine #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
        .Clock(Clock), .Reset(Reset), .Go(Go), .Cmd(Cmd), .TxData(TxData),
        .SendAck(SendAck), .RxData(RxData), .AckReceived(AckReceived),
        .ArbLost(ArbLost), .Busy(Busy), .Done(Done), .SCL(SCL), .SDA(sdaBus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the engine idle; returns at the negedge of the Done cycle.
    task automatic runCmd(input logic [1:0] c, input logic [DW-1:0] tx, input logic ack,
                          input logic [8:0] slave, output int n);
        n = (c == 2'b00 || c == 2'b11) ? BT : NMAX;
        Go = 1'b1; Cmd = c; TxData = tx; SendAck = ack;
        @(negedge Clock);
        Go = 1'b0;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) @(negedge Clock);
            sclLog[k] = SCL; sdaLog[k] = sdaBus; busyLog[k] = Busy;
            doneLog[k] = Done; arbLog[k] = ArbLost;
            if (n > BT && k < n && k % BT == 0) slaveLow = ~slave[8 - k / BT];
            else if (k == n) slaveLow = 1'b0;
        end
    endtask

    task automatic checkTiming(input string tag, input int n);
        int busyCnt = 0;
        int doneEarly = 0;
        for (int k = 0; k < n; k++) begin
            busyCnt += int'(busyLog[k]);
            doneEarly += int'(doneLog[k]);
        end
        check({tag, "_busy_cycles"}, busyCnt, n);
        check({tag, "_done_at_end"}, {doneEarly[7:0], doneLog[n], busyLog[n]}, {8'd0, 2'b10});
        @(negedge Clock);
        check({tag, "_done_one_cycle"}, {Done, Busy}, 2'b00);
    endtask

    task automatic verifyData(input logic rd, input logic [DW-1:0] tx, input logic ack,
                              input logic [8:0] slave, input int n, input string tag);
        logic [8:0] expBits, obsBits;
        logic       master, w;
        int         cnt, arbBit, arbErr;
        arbBit = -1;
        expBits = '0;
        if (rd) begin
            expBits = {slave[8:1], slave[0] & ~ack};
        end else begin
            for (int b = 0; b < DW; b++) begin
                master = (arbBit >= 0) ? 1'b1 : tx[DW-1-b];
                w = master & slave[8-b];
                expBits[8-b] = w;
                if (master && !w && arbBit < 0) arbBit = b;
            end
            expBits[0] = slave[0];
        end
        obsBits = '0; cnt = 0;
        for (int k = 1; k < n; k++)
            if (sclLog[k] && !sclLog[k-1]) begin
                obsBits = {obsBits[7:0], sdaLog[k]};
                cnt++;
            end
        check({tag, "_scl_rises"}, cnt, 9);
        check({tag, "_sda_bits"}, obsBits, expBits);
        arbErr = 0;
        for (int k = 0; k < n; k++)
            if (arbLog[k] !== (arbBit >= 0 && k > arbBit * BT + 2 * CD)) arbErr++;
        check({tag, "_arb_timeline"}, arbErr, 0);
        if (rd) lastRx = slave[8:1];
        else    lastAck = ~slave[0];
        check({tag, "_rxdata"}, RxData, lastRx);
        check({tag, "_ackrx"}, AckReceived, lastAck);
    endtask

    initial begin
        int n;
        int errs;
        int doneCnt;
        logic [1:0] c;
        logic [DW-1:0] tx;
        logic [8:0] slave;
        logic ack;

        Reset = 1'b1; Go = 1'b0; Cmd = 2'b00; TxData = '0; SendAck = 1'b0; slaveLow = 1'b0;
        lastRx = '0; lastAck = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("reset_pins", {SCL, sdaBus}, 2'b11);
        check("reset_flags", {Busy, Done, AckReceived, ArbLost}, 4'b0000);
        check("reset_rxdata", RxData, 0);

        // START
        runCmd(2'b00, '0, 1'b0, 9'h1FF, n);
        check("start_q1", {sclLog[2*CD-1], sdaLog[2*CD-1]}, 2'b11);
        check("start_sda_fall", {sclLog[2*CD], sdaLog[2*CD]}, 2'b10);
        check("start_q3", {sclLog[3*CD], sdaLog[3*CD]}, 2'b00);
        checkTiming("start", n);

        // WRITE A5 acked by the slave
        runCmd(2'b01, 8'hA5, 1'b0, 9'h1FE, n);
        verifyData(1'b0, 8'hA5, 1'b0, 9'h1FE, n, "wr_a5");
        check("wr_a5_flags", {AckReceived, ArbLost}, 2'b10);
        checkTiming("wr_a5", n);

        // WRITE FF with the slave pulling SDA low in bit 5
        runCmd(2'b01, 8'hFF, 1'b0, 9'b111110111, n);
        verifyData(1'b0, 8'hFF, 1'b0, 9'b111110111, n, "wr_arb");
        check("wr_arb_flags", {AckReceived, ArbLost}, 2'b01);
        checkTiming("wr_arb", n);

        // READ 3C with NACK
        runCmd(2'b10, '0, 1'b0, {8'h3C, 1'b1}, n);
        verifyData(1'b1, '0, 1'b0, {8'h3C, 1'b1}, n, "rd_3c");
        checkTiming("rd_3c", n);

        for (int i = 0; i < 6; i++) begin
            c = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
            tx = DW'($urandom);
            slave = 9'($urandom) | 9'($urandom);
            ack = 1'($urandom);
            runCmd(c, tx, ack, slave, n);
            verifyData(c == 2'b10, tx, ack, slave, n, $sformatf("rand%0d", i));
            checkTiming($sformatf("rand%0d", i), n);
        end

        // Go held high: only the Done cycle may accept
        Go = 1'b1; Cmd = 2'b00;
        errs = 0; doneCnt = 0;
        for (int k = 0; k < 3 * (BT + 1); k++) begin
            @(negedge Clock);
            if (Busy !== ((k % (BT + 1)) != BT)) errs++;
            if (Done !== ((k % (BT + 1)) == BT)) errs++;
            doneCnt += int'(Done);
        end
        Go = 1'b0;
        check("b2b_pattern", errs, 0);
        check("b2b_done_count", doneCnt, 3);

        // STOP
        runCmd(2'b11, '0, 1'b0, 9'h1FF, n);
        check("stop_q0", {sclLog[0], sdaLog[0]}, 2'b00);
        check("stop_q1", {sclLog[2*CD-1], sdaLog[2*CD-1]}, 2'b10);
        check("stop_sda_rise", {sclLog[2*CD], sdaLog[2*CD]}, 2'b11);
        check("stop_final", {sclLog[n], sdaLog[n]}, 2'b11);
        checkTiming("stop", n);

        // Reset during READ bit 3
        Go = 1'b1; Cmd = 2'b10; SendAck = 1'b1;
        @(negedge Clock);
        Go = 1'b0;
        repeat (3 * BT + 5) @(negedge Clock);
        check("midrd_busy", Busy, 1'b1);
        Reset = 1'b1;
        @(negedge Clock);
        check("midrd_reset_pins", {SCL, sdaBus}, 2'b11);
        check("midrd_reset_flags", {Busy, Done, AckReceived, ArbLost}, 4'b0000);
        check("midrd_reset_rx", RxData, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        check("midrd_no_done", {Busy, Done, SCL, sdaBus}, 4'b0011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
